// File: rtl/arq_transmitter.sv
// Go-back-N ARQ transmitter: tags payload beats with sequence numbers, keeps them
// in a retransmit window, retires on cumulative acks, replays on timeout.
// Optional statistics counters are enabled with `define ARQ_TX_STATS_EN.
module arq_transmitter #(
  parameter int DATA_W  = 32,
  parameter int SEQ_W   = 4,
  parameter int WINDOW  = 8,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEQ_W-1:0]  out_seq,
  output logic [DATA_W-1:0] out_data,
  input  logic              ack_valid,
  output logic              ack_ready,
  input  logic [SEQ_W-1:0]  ack_seq
`ifdef ARQ_TX_STATS_EN
  ,
  output logic [31:0]       stat_retx,
  output logic [15:0]       stat_bad_ack
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_REWIND = 2'd2;

  localparam int IDX_W = $clog2(WINDOW);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [SEQ_W:0]   WIN      = (SEQ_W+1)'(WINDOW);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [SEQ_W-1:0]  base_ptr, send_ptr, next_ptr;
  logic [SEQ_W-1:0]  base_nx, send_nx, next_nx;
  logic [SEQ_W-1:0]  inflight, sent_cnt, ack_dist;
  logic [1:0]        state;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] buf_mem [WINDOW];
  logic              in_fire, out_fire, stalled, ack_hit, rewind_go;

  // All pointer arithmetic is modular, so distances stay correct across the wrap.
  assign inflight = next_ptr - base_ptr;
  assign sent_cnt = send_ptr - base_ptr;
  assign ack_dist = ack_seq - base_ptr;

  assign in_ready  = !rst && ({1'b0, inflight} < WIN);
  assign ack_ready = !rst;
  assign out_valid = (send_ptr != next_ptr);
  assign out_seq   = send_ptr;
  assign out_data  = buf_mem[send_ptr[IDX_W-1:0]];

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign stalled   = out_valid && !out_ready;
  assign ack_hit   = ack_valid && !rst && (ack_dist != '0) && (ack_dist <= inflight);
  assign rewind_go = (state == ST_REWIND) && (base_ptr != next_ptr) && !stalled;

  assign base_nx = ack_hit ? ack_seq : base_ptr;
  assign next_nx = in_fire ? next_ptr + 1'b1 : next_ptr;

  // Rewind beats everything; an ack past the send pointer skips already-delivered beats.
  always_comb begin
    send_nx = send_ptr;
    if (rewind_go)
      send_nx = base_nx;
    else if (ack_hit && (sent_cnt < ack_dist))
      send_nx = ack_seq;
    else if (out_fire)
      send_nx = send_ptr + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_ptr <= '0;
      send_ptr <= '0;
      next_ptr <= '0;
      state    <= ST_IDLE;
      timer    <= '0;
    end else begin
      base_ptr <= base_nx;
      send_ptr <= send_nx;
      next_ptr <= next_nx;
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (base_nx != next_nx) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (base_nx == next_nx) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (ack_hit)
            timer <= '0;
          else if (timer == TMR_LAST)
            state <= ST_REWIND;
          else
            timer <= timer + 1'b1;
        end
        ST_REWIND: begin
          if ((base_ptr == next_ptr) || rewind_go) begin
            timer <= '0;
            state <= (base_nx == next_nx) ? ST_IDLE : ST_ACTIVE;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  // NOTE: the payload memory has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (in_fire) buf_mem[next_ptr[IDX_W-1:0]] <= in_data;
  end

`ifdef ARQ_TX_STATS_EN
  // high_ptr is one past the highest seq ever sent; beats below it are replays.
  logic [SEQ_W-1:0] high_ptr;
  logic             retx_hit, bad_hit;

  assign retx_hit = out_fire && (sent_cnt < (high_ptr - base_ptr));
  assign bad_hit  = ack_valid && !rst && (ack_dist != '0) && (ack_dist > inflight);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_ptr     <= '0;
      stat_retx    <= '0;
      stat_bad_ack <= '0;
    end else begin
      if (ack_hit && ((high_ptr - base_ptr) < ack_dist))
        high_ptr <= ack_seq;
      else if (out_fire && (send_ptr == high_ptr))
        high_ptr <= send_ptr + 1'b1;
      if (retx_hit && (stat_retx != '1))   stat_retx    <= stat_retx + 1'b1;
      if (bad_hit && (stat_bad_ack != '1)) stat_bad_ack <= stat_bad_ack + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_arq_transmitter.sv
// Directed bench for arq_transmitter: table-driven basic flow plus hand-written
// window-full, timeout replay, stalled rewind, random link and bad-ack sequences.
module tb_arq_transmitter;
  localparam int DATA_W = 32, SEQ_W = 4, WINDOW = 8, TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_ready;
  logic [SEQ_W-1:0]  out_seq;
  logic [DATA_W-1:0] out_data;
  logic              ack_valid, ack_ready;
  logic [SEQ_W-1:0]  ack_seq;
`ifdef ARQ_TX_STATS_EN
  logic [31:0]       stat_retx;
  logic [15:0]       stat_bad_ack;
`endif

  arq_transmitter #(.DATA_W(DATA_W), .SEQ_W(SEQ_W), .WINDOW(WINDOW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq), .out_data(out_data),
    .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_seq(ack_seq)
`ifdef ARQ_TX_STATS_EN
    , .stat_retx(stat_retx), .stat_bad_ack(stat_bad_ack)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        av;
    logic [3:0]  aseq;
    logic        e_irdy;
    logic        e_ov;
    logic [3:0]  e_seq;
    logic [31:0] e_data;
  } vec_t;

  typedef struct {
    logic [3:0]  seq;
    logic [31:0] data;
  } beat_t;

  vec_t  vecs [7];
  beat_t log_q [$];
  int    tests = 0;
  int    failed = 0;

  always @(negedge clk)
    if (!rst && out_valid && out_ready) log_q.push_back('{out_seq, out_data});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic av, input logic [3:0] aseq);
    @(posedge clk);
    #1;
    in_valid = iv; in_data = id; out_ready = ordy; ack_valid = av; ack_seq = aseq;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ack_valid = 1'b0; ack_seq = '0;
    repeat (2) @(negedge clk);
    log_q.delete();
    check("reset_in_ready", in_ready, 0);
    check("reset_ack_ready", ack_ready, 0);
    check("reset_out_valid", out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int  accepts, k_push, rx_cnt;
    logic [3:0] rx_exp, last_seq;
    bit  bad, saw_wrap, have_last;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ack_valid = 1'b0; ack_seq = '0;

    // Push 3 beats with the link ready, then cumulative acks 1,2,3.
    vecs[0] = '{1'b1, 32'hA000_0000, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0};
    vecs[1] = '{1'b1, 32'hA000_0001, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 32'hA000_0000};
    vecs[2] = '{1'b1, 32'hA000_0002, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 32'hA000_0001};
    vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd2, 32'hA000_0002};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 32'h0};
    vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 32'h0};
    vecs[6] = '{1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].av, vecs[i].aseq);
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_irdy);
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d_out_seq", i), out_seq, vecs[i].e_seq);
        check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_data);
      end
    end
    check("basic_base", dut.base_ptr, 3);
    check("basic_timer_idle", dut.timer, 0);

    // Window full after 8 accepts; ack 2 frees exactly two slots.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hB000_0000 + i, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      check($sformatf("fill%0d_in_ready", i), in_ready, 1);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd2);
    @(negedge clk);
    check("full_before_ack_in_ready", in_ready, 0);
    accepts = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hB000_0100 + i, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      if (in_valid && in_ready) accepts++;
    end
    check("after_ack_accepts", accepts, 2);

    // Send 0..3, no acks: timeout replays from 0 with identical data.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hE000_0000 + i, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    for (int c = 0; c < 200 && log_q.size() < 8; c++) @(negedge clk);
    check("replay_count_ok", log_q.size() >= 8, 1);
    for (int i = 0; i < 8; i++)
      if (log_q.size() > i) begin
        check($sformatf("replay%0d_seq", i), log_q[i].seq, i % 4);
        check($sformatf("replay%0d_data", i), log_q[i].data, 32'hE000_0000 + (i % 4));
      end

    // Timeout while stalled: beat holds, rewind applies on the transfer cycle.
    do_reset();
    drive(1'b1, 32'hF000_0000, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 32'hF000_0001, 1'b0, 1'b0, 4'd0);
    bad = 1'b0;
    for (int i = 0; i < 2 * TIMEOUT; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      if (!out_valid || out_seq != 4'd0 || out_data != 32'hF000_0000) bad = 1'b1;
    end
    check("stall_hold_stable", bad, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    check("stall_release_seq", out_seq, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    check("rewound_seq", out_seq, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    check("stall_log_size", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      check("stall_log0", log_q[0].seq, 0);
      check("stall_log1", log_q[1].seq, 0);
      check("stall_log2", log_q[2].seq, 1);
      check("stall_log2_data", log_q[2].data, 32'hF000_0001);
    end

    // 40 beats over a lossy-ready link with an in-order receiver model.
    do_reset();
    k_push = 0; rx_cnt = 0; rx_exp = '0; last_seq = '0;
    saw_wrap = 1'b0; have_last = 1'b0;
    for (int cyc = 0; cyc < 5000 && rx_cnt < 40; cyc++) begin
      drive(k_push < 40, 32'hC000_0000 + k_push, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, rx_exp);
      @(negedge clk);
      if (in_valid && in_ready) k_push++;
      if (out_valid && out_ready) begin
        if (have_last && last_seq == 4'd15 && out_seq == 4'd0) saw_wrap = 1'b1;
        last_seq = out_seq;
        have_last = 1'b1;
        if (out_seq == rx_exp) begin
          check($sformatf("rx%0d_data", rx_cnt), out_data, 32'hC000_0000 + rx_cnt);
          rx_cnt++;
          rx_exp++;
        end
      end
    end
    check("rx_count", rx_cnt, 40);
    check("seq_wrapped", saw_wrap, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, rx_exp);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    check("final_base", dut.base_ptr, 8);
    check("final_out_valid", out_valid, 0);

    // Out-of-range and duplicate acks are ignored; ack == next retires all.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hD000_0000 + i, 1'b1, 1'b0, 4'd0);
    repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd5);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    check("bad_ack_base", dut.base_ptr, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    check("dup_ack_base", dut.base_ptr, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd3);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    check("full_ack_base", dut.base_ptr, 3);
    check("full_ack_out_valid", out_valid, 0);
`ifdef ARQ_TX_STATS_EN
    check("stat_bad_ack", stat_bad_ack, 1);
    check("stat_retx", stat_retx, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
